instr_mem_writer: RTL and testbench

//  Y86-64 instruction encoder/loader: the write side of the instruction memory that the fetch stage reads.

---
 rtl/instr_mem_writer.sv | 120 ++++++++++++
 tb/tb_instr_mem_writer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_writer.sv
// Y86-64 instruction encoder/loader: turns one decoded instruction into its
// variable-length byte image and writes it, one byte per cycle, into instruction memory.
module instr_mem_writer #(
    parameter int DATA_WID  = 64,
    parameter int ADDR_WID  = 11,
    parameter int MEM_DEPTH = 2048
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic [3:0]          rA,
    input  logic [3:0]          rB,
    input  logic [DATA_WID-1:0] valC,
    input  logic                ptr_load,
    input  logic [ADDR_WID-1:0] ptr_value,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_WID-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                busy,
    output logic                bad_icode,
    output logic [DATA_WID-1:0] next_pc
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state;
    logic [ADDR_WID-1:0] ptr;
    logic [ADDR_WID-1:0] ptr_next;
    logic [79:0]         image;      // remaining bytes, next one to write in [7:0]
    logic [3:0]          remaining;
    logic [79:0]         image_in;
    logic [3:0]          len_in;     // 0 marks an invalid icode

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        image_in = '0;
        len_in   = 4'd0;
        case (icode)
            4'h0, 4'h1, 4'h9: begin
                image_in = {72'd0, icode, ifun};
                len_in   = 4'd1;
            end
            4'h2, 4'h6, 4'hA, 4'hB: begin
                image_in = {64'd0, rA, rB, icode, ifun};
                len_in   = 4'd2;
            end
            4'h7, 4'h8: begin
                image_in = {8'd0, valC, icode, ifun};
                len_in   = 4'd9;
            end
            4'h3, 4'h4, 4'h5: begin
                image_in = {valC, rA, rB, icode, ifun};
                len_in   = 4'd10;
            end
            default: begin
                image_in = '0;
                len_in   = 4'd0;
            end
        endcase
    end

    assign ptr_next  = (ptr == ADDR_WID'(MEM_DEPTH - 1)) ? '0 : ptr + 1'b1;

    // A pointer load in IDLE takes priority, so acceptance is withheld that same cycle.
    assign in_ready  = (state == IDLE) && !ptr_load;
    assign mem_addr  = ptr;
    assign mem_wdata = image[7:0];
    assign next_pc   = {{(DATA_WID - ADDR_WID){1'b0}}, ptr};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            image     <= '0;
            remaining <= 4'd0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            bad_icode <= 1'b0;
        end else begin
            bad_icode <= 1'b0;
            case (state)
                IDLE: begin
                    if (ptr_load) begin
                        ptr <= ptr_value;
                    end else if (in_valid) begin
                        if (len_in != 4'd0) begin
                            image     <= image_in;
                            remaining <= len_in;
                            state     <= EMIT;
                            mem_we    <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            bad_icode <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Without mem_ready everything holds, keeping address and data stable.
                    if (mem_ready) begin
                        ptr       <= ptr_next;
                        image     <= image >> 8;
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state  <= IDLE;
                            mem_we <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Scoreboard bench for instr_mem_writer: a byte-image model fills an expectation queue,
// a negedge monitor pops it on every accepted memory write.
module tb_instr_mem_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
    logic [63:0] valC = '0;
    logic        ptr_load = 1'b0;
    logic [10:0] ptr_value = '0;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        bad_icode;
    logic [63:0] next_pc;

    instr_mem_writer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
        .ptr_load(ptr_load), .ptr_value(ptr_value),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .bad_icode(bad_icode), .next_pc(next_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the main sequence
    int  model_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) mem_ready = 1'b1;
        else if (ready_mode == 1) mem_ready = ($urandom % 3) != 0;
    end

    // Monitor: compares each accepted write and checks stability across stalls.
    initial begin
        logic        prev_stall;
        logic [10:0] pa;
        logic [7:0]  pd;
        wr_t         e;
        prev_stall = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_we", mem_we, 1);
                    check("hold_addr", mem_addr, pa);
                    check("hold_data", mem_wdata, pd);
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", mem_addr, e.addr);
                        check("wr_data", mem_wdata, e.data);
                    end
                end
                prev_stall = mem_we && !mem_ready;
                pa = mem_addr;
                pd = mem_wdata;
            end
        end
    end

    // Reference model: byte image from the encoding rules, placed at the model pointer.
    task automatic model_push(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] vc);
        int         n;
        logic [7:0] b[$];
        case (ic)
            4'h0, 4'h1, 4'h9:       n = 1;
            4'h2, 4'h6, 4'hA, 4'hB: n = 2;
            4'h7, 4'h8:             n = 9;
            4'h3, 4'h4, 4'h5:       n = 10;
            default:                n = 0;
        endcase
        if (n == 0) return;
        b.push_back({ic, ifn});
        if (n == 2 || n == 10) b.push_back({ra, rb});
        if (n >= 9) for (int k = 0; k < 8; k++) b.push_back(vc[8*k +: 8]);
        foreach (b[i]) begin
            exp_q.push_back('{addr: 11'(model_ptr), data: b[i]});
            model_ptr = (model_ptr + 1) % 2048;
        end
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, output int t);
        int k;
        icode = ic; ifun = ifn; rA = ra; rB = rb; valC = vc;
        in_valid = 1'b1;
        for (k = 0; k < 100; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (k == 100) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        @(posedge clk);
        model_push(ic, ifn, ra, rb, vc);
        #1;
        in_valid = 1'b0;
        icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        valC = {$urandom, $urandom};
        @(negedge clk);
        check("bad_icode", bad_icode, ic > 4'hB);
        check("we_after_accept", mem_we, ic <= 4'hB);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !mem_we) break;
        end
        if (k == 400) fail_now("drain_timeout");
        check("next_pc", next_pc, 64'(model_ptr));
    endtask

    // Pointer load with a competing valid instruction that must not be taken.
    task automatic load_ptr(input int v);
        @(posedge clk);
        #1;
        ptr_load = 1'b1;
        ptr_value = 11'(v);
        in_valid = 1'b1;
        icode = 4'h0;
        @(negedge clk);
        check("in_ready_during_load", in_ready, 0);
        @(posedge clk);
        #1;
        ptr_load = 1'b0;
        in_valid = 1'b0;
        model_ptr = v;
        @(negedge clk);
        check("no_accept_on_load", mem_we, 0);
        check("ptr_loaded", next_pc, 64'(v));
    endtask

    initial begin
        int t1, t2;
        logic [3:0] ic;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_bad_icode", bad_icode, 0);
        check("rst_next_pc", next_pc, 0);

        // irmovq at 0
        send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, t1);
        wait_idle();

        // jXX at 0x20
        load_ptr(32'h20);
        send(4'h7, 4'h3, 4'h0, 4'h0, 64'h40, t1);
        wait_idle();

        // halt then addq back-to-back
        load_ptr(0);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, t1);
        send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, t2);
        check("halt_addq_gap", 64'(t2 - t1), 2);
        wait_idle();

        // rrmovq with a three-cycle stall on byte 1
        ready_mode = 2;
        mem_ready = 1'b1;
        send(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, t1);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        wait_idle();
        ready_mode = 0;

        // mrmovq wrapping the top of memory
        load_ptr(2046);
        send(4'h5, 4'h0, 4'h1, 4'h2, 64'hFEDCBA9876543210, t1);
        wait_idle();

        // invalid icode: single pulse, nothing written
        send(4'hC, 4'h0, 4'h1, 4'h2, 64'h0, t1);
        @(negedge clk);
        check("bad_icode_single_pulse", bad_icode, 0);
        wait_idle();

        // full-length throughput: irmovq then nop
        send(4'h3, 4'h0, 4'hF, 4'h4, 64'h1122334455667788, t1);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, t2);
        check("irmovq_gap", 64'(t2 - t1), 11);
        wait_idle();

        // reset while byte 4 of irmovq is presented
        send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, t1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_bytes_left", 64'(exp_q.size()), 6);
        check("abort_mem_we", mem_we, 0);
        check("abort_next_pc", next_pc, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        exp_q.delete();
        model_ptr = 0;

        // randomized traffic with random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom % 5 == 0) begin
                wait_idle();
                load_ptr(int'($urandom % 2048));
            end
            ic = ($urandom % 8 == 0) ? 4'(12 + $urandom % 4) : 4'($urandom % 12);
            send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, t1);
            if ($urandom % 2 == 0) wait_idle();
        end
        wait_idle();
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
